// File: rtl/dual_rail_value_extract.sv
// dual_rail_value_extract: dual-rail link receiver; decodes codewords to a valid/ready port and returns ack.
// ENC "TP" selects two-phase (transition per token); any other value selects four-phase return-to-zero.
// Define DR_EXTRACT_SYNC_EN to put a 2-flop synchroniser on every rail (adds 2 clk of latency).
module dual_rail_value_extract #(
    parameter ENC = "TP",
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0][1:0]  in,
    output logic                   ack,
    output logic [WIDTH-1:0]       data,
    output logic                   valid,
    input  logic                   ready,
    output logic                   err
);
    localparam int RAIL_NUM = 2;
    localparam bit TP = (ENC == "TP");

    typedef enum logic [1:0] {IDLE, HOLD, ACK} state_t;

    state_t                          state, state_nx;
    logic [WIDTH-1:0][RAIL_NUM-1:0]  r, t, ph, ph_nx;
    logic [WIDTH-1:0]                t1, t0, data_nx;
    logic                            ack_nx, valid_nx, err_nx;
    logic                            complete, illegal, spacer;

`ifdef DR_EXTRACT_SYNC_EN
    logic [WIDTH-1:0][RAIL_NUM-1:0]  s1, s2;
    // two-flop metastability guard on every rail
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    assign r = s2;
`else
    assign r = in;
`endif

    // two-phase tokens are rail transitions relative to the last acknowledged rail levels
    assign t = TP ? (r ^ ph) : r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign t1[i] = t[i][1];
        assign t0[i] = t[i][0];
    end

    assign complete = &(t1 ^ t0);
    assign illegal  = |(t1 & t0);
    assign spacer   = (r == '0);

    // handshake FSM: decode in IDLE, present in HOLD, acknowledge the link in ACK
    always_comb begin
        state_nx = state;
        ack_nx   = ack;
        data_nx  = data;
        valid_nx = valid;
        err_nx   = err;
        ph_nx    = ph;
        case (state)
            IDLE: begin
                if (illegal) begin
                    err_nx = 1'b1;
                end else if (complete) begin
                    data_nx  = t1;
                    valid_nx = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    valid_nx = 1'b0;
                    state_nx = ACK;
                    if (!TP) ack_nx = 1'b1;
                end
            end
            ACK: begin
                if (TP) begin
                    ph_nx    = r;
                    ack_nx   = ~ack;
                    state_nx = IDLE;
                end else begin
                    if (illegal) err_nx = 1'b1;
                    if (spacer) begin
                        ack_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
            ph    <= '0;
        end else begin
            state <= state_nx;
            ack   <= ack_nx;
            data  <= data_nx;
            valid <= valid_nx;
            err   <= err_nx;
            ph    <= ph_nx;
        end
endmodule
